// File: rtl/maxpool2x2_stream.sv
// 2x2 max-pool over a raster pixel stream.
// Row-pair pooling uses a half-width line buffer and a single output register.
module maxpool2x2_stream #(
  parameter int N_DATA = 32,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_DATA-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_DATA-1:0] out_data,
  output logic              out_last
);

  localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int LD = IMG_W / 2;
  localparam int LW = (LD > 1) ? $clog2(LD) : 1;

  localparam logic [0:0] ROW_EVEN = 1'b0;
  localparam logic [0:0] ROW_ODD  = 1'b1;

  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic [0:0]        r_state;
  logic [N_DATA-1:0] r_hold;
  logic [N_DATA-1:0] r_linebuf [LD];
  logic              r_out_valid;
  logic [N_DATA-1:0] r_out_data;
  logic              r_out_last;

  logic              w_accept;
  logic              w_col_end;
  logic              w_row_end;
  logic [CW-1:0]     w_half;
  logic [LW-1:0]     w_idx;
  logic [N_DATA-1:0] w_hmax;
  logic [N_DATA-1:0] w_vmax;
  logic              w_load;

  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_col_end = (r_col == CW'(IMG_W - 1));
  assign w_row_end = (r_row == RW'(IMG_H - 1));
  assign w_half    = r_col >> 1;
  assign w_idx     = w_half[LW-1:0];

  assign w_hmax = (in_data > r_hold) ? in_data : r_hold;
  assign w_vmax = (r_linebuf[w_idx] > w_hmax) ? r_linebuf[w_idx] : w_hmax;
  assign w_load = w_accept && (r_state == ROW_ODD) && r_col[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_col_end) begin
        r_col <= '0;
        r_row <= w_row_end ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ROW_EVEN;
    end else if (w_accept && w_col_end) begin
      r_state <= (r_state == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold <= '0;
    end else if (w_accept && !r_col[0]) begin
      r_hold <= in_data;
    end
  end

  // Every entry is written on an even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (w_accept && r_col[0] && (r_state == ROW_EVEN)) begin
      r_linebuf[w_idx] <= w_hmax;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_vmax;
      r_out_last  <= w_row_end && w_col_end;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;

endmodule
